// File: rtl/bundle_fetch.sv
// Instruction-fetch front end for the 6-slot VLIW core: issues bundle reads to a
// 1-cycle synchronous instruction memory and buffers results in a credit-managed FIFO.
module bundle_fetch #(
    parameter int          BUNDLE_W = 192,
    parameter int          ADDR_W   = 8,
    parameter int          DEPTH    = 3,
    parameter logic [31:0] RESET_PC = 32'd0
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                imem_en,
    output logic [ADDR_W-1:0]   imem_addr,
    input  logic [BUNDLE_W-1:0] imem_data,
    input  logic                redirect_valid,
    input  logic [31:0]         redirect_pc,
    output logic                bundle_valid,
    input  logic                bundle_ready,
    output logic [BUNDLE_W-1:0] bundle,
    output logic [31:0]         bundle_pc,
    output logic [31:0]         fetch_pc
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [BUNDLE_W-1:0] fifo_bundle [DEPTH];
    logic [31:0]         fifo_pc     [DEPTH];
    logic [PTR_W-1:0]    rd_ptr;
    logic [PTR_W-1:0]    wr_ptr;
    logic [CNT_W-1:0]    count;
    logic                inflight;
    logic [31:0]         inflight_pc;
    logic [CNT_W:0]      used;
    logic                issue;
    logic                push;
    logic                pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // An outstanding read holds a FIFO slot, so a full FIFO can never be pushed.
    assign used  = {1'b0, count} + (CNT_W + 1)'(inflight);
    assign issue = rst_n && !redirect_valid && (used < (CNT_W + 1)'(DEPTH));
    assign push  = inflight && !redirect_valid;
    assign pop   = bundle_valid && bundle_ready;

    assign imem_en      = issue;
    assign imem_addr    = fetch_pc[ADDR_W-1:0];
    assign bundle_valid = (count != '0);
    assign bundle       = bundle_valid ? fifo_bundle[rd_ptr] : '0;
    assign bundle_pc    = bundle_valid ? fifo_pc[rd_ptr] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_pc;
            inflight <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            inflight <= issue;
            if (issue) begin
                inflight_pc <= fetch_pc;
                fetch_pc    <= fetch_pc + 32'd1;
            end
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: payload storage is not reset; count gates every read so stale contents never leak.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_bundle[wr_ptr] <= imem_data;
            fifo_pc[wr_ptr]     <= inflight_pc;
        end
    end

endmodule

// File: tb/tb_bundle_fetch.sv
// Self-checking bench for bundle_fetch: behavioural instruction memory plus a
// scoreboard of expected delivered PCs checked on every handshake.
module tb_bundle_fetch;

    localparam int BUNDLE_W = 192;
    localparam int ADDR_W   = 8;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                imem_en;
    logic [ADDR_W-1:0]   imem_addr;
    logic [BUNDLE_W-1:0] imem_data = '0;
    logic                redirect_valid = 1'b0;
    logic [31:0]         redirect_pc = '0;
    logic                bundle_valid;
    logic                bundle_ready = 1'b0;
    logic [BUNDLE_W-1:0] bundle;
    logic [31:0]         bundle_pc;
    logic [31:0]         fetch_pc;

    int          tests_run = 0;
    int          failed    = 0;
    int          delivered = 0;
    logic [31:0] exp_q[$];

    bundle_fetch dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_en        (imem_en),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .bundle_valid   (bundle_valid),
        .bundle_ready   (bundle_ready),
        .bundle         (bundle),
        .bundle_pc      (bundle_pc),
        .fetch_pc       (fetch_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [BUNDLE_W-1:0] bundle_of(input logic [7:0] a);
        logic [BUNDLE_W-1:0] r;
        r = '0;
        for (int k = 0; k < 6; k++)
            r[32*k +: 32] = {8'hC0 + 8'(k), a ^ 8'h5A, 8'(k), a};
        return r;
    endfunction

    always @(posedge clk) begin
        if (imem_en) imem_data <= bundle_of(imem_addr);
    end

    // Scoreboard: every handshake must deliver the next expected PC and its memory image.
    always @(negedge clk) begin
        logic [31:0] exp_pc;
        if (rst_n) begin
            tests_run++;
            if (int'(dut.count) > 3 || (dut.push && int'(dut.count) == 3)) begin
                failed++;
                $display("FAIL occupancy: count %0d push %0b, required count <= 3 and no push when full",
                         dut.count, dut.push);
            end
        end
        if (bundle_valid && bundle_ready) begin
            tests_run++;
            delivered++;
            if (exp_q.size() == 0) begin
                failed++;
                $display("FAIL unexpected_bundle: got pc %0h, none expected", bundle_pc);
            end else begin
                exp_pc = exp_q.pop_front();
                if (bundle_pc !== exp_pc || bundle !== bundle_of(exp_pc[7:0])) begin
                    failed++;
                    $display("FAIL delivered: got pc %0h data %h, required pc %0h data %h",
                             bundle_pc, bundle, exp_pc, bundle_of(exp_pc[7:0]));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic refill(input logic [31:0] start, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(start + 32'(i));
    endtask

    task automatic do_reset(input logic rdy);
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        bundle_ready   = rdy;
        repeat (2) @(posedge clk);
        #1;
        exp_q.delete();
        delivered = 0;
        rst_n     = 1'b1;
    endtask

    task automatic test_reset();
        #2;
        tests_run++;
        if ({imem_en, bundle_valid, bundle_pc, fetch_pc} !== {1'b0, 1'b0, 32'd0, 32'd0} || bundle !== '0) begin
            failed++;
            $display("FAIL reset_state: en %0b valid %0b pc %0h fetch_pc %0h bundle %h, required all 0",
                     imem_en, bundle_valid, bundle_pc, fetch_pc, bundle);
        end
    endtask

    task automatic test_stream();
        do_reset(1'b1);
        refill(32'd0, 64);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            tests_run++;
            if ({imem_en, imem_addr} !== {1'b1, 8'(c)}) begin
                failed++;
                $display("FAIL stream_issue c%0d: en %0b addr %0h, required en 1 addr %0h", c, imem_en, imem_addr, c);
            end
            tests_run++;
            if (bundle_valid !== (c >= 2)) begin
                failed++;
                $display("FAIL stream_valid c%0d: got %0b, required %0b", c, bundle_valid, c >= 2);
            end
            step();
        end
        tests_run++;
        if (delivered != 6) begin
            failed++;
            $display("FAIL stream_count: got %0d, required 6", delivered);
        end
    endtask

    task automatic test_backpressure();
        int          issues;
        logic [7:0]  addrs[$];
        logic        ok;
        issues = 0;
        do_reset(1'b0);
        refill(32'd0, 64);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (imem_en) begin
                issues++;
                addrs.push_back(imem_addr);
            end
            if (c == 5) begin
                tests_run++;
                if ({bundle_valid, bundle_pc} !== {1'b1, 32'd0}) begin
                    failed++;
                    $display("FAIL bp_head: valid %0b pc %0h, required 1 0", bundle_valid, bundle_pc);
                end
            end
            step();
        end
        ok = (addrs.size() == 3) && addrs[0] == 8'd0 && addrs[1] == 8'd1 && addrs[2] == 8'd2;
        tests_run++;
        if (issues != 3 || !ok) begin
            failed++;
            $display("FAIL bp_issues: got %0d issues, required 3 at addresses 0,1,2", issues);
        end
        bundle_ready = 1'b1;
        for (int c = 6; c < 12; c++) begin
            @(negedge clk);
            if (c == 6) begin
                tests_run++;
                if (imem_en !== 1'b0) begin
                    failed++;
                    $display("FAIL bp_no_issue_on_pop: en %0b, required 0", imem_en);
                end
            end
            if (c == 7) begin
                tests_run++;
                if ({imem_en, imem_addr} !== {1'b1, 8'd3}) begin
                    failed++;
                    $display("FAIL bp_resume: en %0b addr %0h, required en 1 addr 3", imem_en, imem_addr);
                end
            end
            step();
        end
        tests_run++;
        if (delivered != 6) begin
            failed++;
            $display("FAIL bp_count: got %0d, required 6", delivered);
        end
    endtask

    // Bring the FIFO to {5,6} with the read of 7 outstanding.
    task automatic prime_5_6_7();
        do_reset(1'b1);
        refill(32'd0, 8);
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            step();
        end
        bundle_ready = 1'b0;
        @(negedge clk);
        step();
    endtask

    task automatic test_redirect();
        prime_5_6_7();
        bundle_ready   = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        @(negedge clk);
        tests_run++;
        if ({imem_en, bundle_valid, bundle_pc} !== {1'b0, 1'b1, 32'd5}) begin
            failed++;
            $display("FAIL redir_cycle: en %0b valid %0b pc %0h, required 0 1 5", imem_en, bundle_valid, bundle_pc);
        end
        step();
        redirect_valid = 1'b0;
        exp_q.delete();
        refill(32'h40, 16);
        tests_run++;
        if (delivered != 6) begin
            failed++;
            $display("FAIL redir_delivered: got %0d, required 6", delivered);
        end
        @(negedge clk);
        tests_run++;
        if ({imem_en, imem_addr, bundle_valid} !== {1'b1, 8'h40, 1'b0}) begin
            failed++;
            $display("FAIL redir_n1: en %0b addr %0h valid %0b, required 1 40 0", imem_en, imem_addr, bundle_valid);
        end
        step();
        @(negedge clk);
        tests_run++;
        if (bundle_valid !== 1'b0) begin
            failed++;
            $display("FAIL redir_n2: valid %0b, required 0", bundle_valid);
        end
        step();
        @(negedge clk);
        tests_run++;
        if ({bundle_valid, bundle_pc} !== {1'b1, 32'h40}) begin
            failed++;
            $display("FAIL redir_n3: valid %0b pc %0h, required 1 40", bundle_valid, bundle_pc);
        end
        step();
    endtask

    task automatic test_wrap();
        int          base;
        logic [7:0]  exp_addr [4];
        exp_addr[0] = 8'hFE; exp_addr[1] = 8'hFF; exp_addr[2] = 8'h00; exp_addr[3] = 8'h01;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h10;
        @(negedge clk);
        tests_run++;
        if (imem_en !== 1'b0) begin
            failed++;
            $display("FAIL hold_redir0: en %0b, required 0", imem_en);
        end
        step();
        redirect_pc = 32'hFE;
        @(negedge clk);
        tests_run++;
        if ({imem_en, fetch_pc} !== {1'b0, 32'h10}) begin
            failed++;
            $display("FAIL hold_redir1: en %0b fetch_pc %0h, required 0 10", imem_en, fetch_pc);
        end
        step();
        redirect_valid = 1'b0;
        exp_q.delete();
        refill(32'hFE, 16);
        base = delivered;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c < 4) begin
                tests_run++;
                if ({imem_en, imem_addr, fetch_pc} !== {1'b1, exp_addr[c], 32'hFE + 32'(c)}) begin
                    failed++;
                    $display("FAIL wrap_issue c%0d: en %0b addr %0h fetch_pc %0h, required 1 %0h %0h",
                             c, imem_en, imem_addr, fetch_pc, exp_addr[c], 32'hFE + 32'(c));
                end
            end
            step();
        end
        tests_run++;
        if (delivered - base != 4) begin
            failed++;
            $display("FAIL wrap_count: got %0d, required 4", delivered - base);
        end
    endtask

    task automatic test_reset_mid();
        prime_5_6_7();
        tests_run++;
        if ({bundle_valid, bundle_pc} !== {1'b1, 32'd5}) begin
            failed++;
            $display("FAIL mid_precondition: valid %0b pc %0h, required 1 5", bundle_valid, bundle_pc);
        end
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({imem_en, imem_addr, bundle_valid, bundle_pc, fetch_pc} !== {1'b0, 8'd0, 1'b0, 32'd0, 32'd0}
            || bundle !== '0) begin
            failed++;
            $display("FAIL mid_reset: en %0b addr %0h valid %0b pc %0h fetch_pc %0h, required all 0",
                     imem_en, imem_addr, bundle_valid, bundle_pc, fetch_pc);
        end
        do_reset(1'b1);
        refill(32'd0, 16);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (c == 2) begin
                tests_run++;
                if ({bundle_valid, bundle_pc} !== {1'b1, 32'd0}) begin
                    failed++;
                    $display("FAIL mid_first: valid %0b pc %0h, required 1 0", bundle_valid, bundle_pc);
                end
            end
            step();
        end
    endtask

    task automatic test_random();
        do_reset(1'b1);
        refill(32'd0, 1100);
        for (int c = 0; c < 1000; c++) begin
            bundle_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            step();
        end
        tests_run++;
        if (delivered < 200 || delivered > 1000) begin
            failed++;
            $display("FAIL random_count: got %0d, required 200..1000", delivered);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
